// File: rtl/inst_loader.sv
`timescale 1ns/1ps
// Program loader: turns UART bytes into big-endian 32-bit words and writes them
// to consecutive instruction-RAM addresses until the halt word has been stored.
module inst_loader #(
  parameter int                         NBIT_DATA_LEN = 8,
  parameter int                         len_data      = 32,
  parameter int                         len_addr      = 11,
  parameter logic [NBIT_DATA_LEN-1:0]   CMD_LOAD      = 8'h01,
  parameter logic [len_data-1:0]        HALT_WORD     = 32'hFC000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
  output logic [len_addr-1:0]      addr_mem_inst,
  output logic [len_data-1:0]      ins_to_mem,
  output logic                     wr_ram_inst,
  output logic                     loading,
  output logic                     load_done,
  output logic                     load_err,
  output logic [len_addr:0]        word_count
);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR} state_t;

  localparam logic [len_addr-1:0] ADDR_LAST = '1;

  state_t              state, state_nxt;
  logic [1:0]          byte_cnt;
  logic [len_data-1:0] shift_word;
  logic [len_addr-1:0] addr;
  logic                is_cmd;

  assign is_cmd = rx_done_tick && (rx_data_in == CMD_LOAD);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: defaulting every always_comb output first prevents latch inference.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (is_cmd) state_nxt = S_RECV;
      S_RECV:  if (rx_done_tick && byte_cnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE: begin
        if (ins_to_mem == HALT_WORD) state_nxt = S_DONE;
        else if (addr == ADDR_LAST)  state_nxt = S_ERR;
        else                         state_nxt = S_RECV;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ram_inst = (state == S_WRITE);
    loading     = (state == S_RECV) || (state == S_WRITE);
    load_done   = (state == S_DONE);
    load_err    = (state == S_ERR);
  end

  // Byte counter wraps 3->0 on entering WRITE, so a tick during WRITE
  // naturally becomes byte 0 of the next word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt      <= '0;
      shift_word    <= '0;
      addr          <= '0;
      addr_mem_inst <= '0;
      ins_to_mem    <= '0;
      word_count    <= '0;
    end else begin
      if (state == S_IDLE && is_cmd) begin
        byte_cnt   <= '0;
        addr       <= '0;
        word_count <= '0;
      end

      if (rx_done_tick && (state == S_RECV || state == S_WRITE)) begin
        shift_word <= {shift_word[len_data-NBIT_DATA_LEN-1:0], rx_data_in};
        byte_cnt   <= byte_cnt + 2'd1;
      end

      if (state == S_RECV && rx_done_tick && byte_cnt == 2'd3) begin
        ins_to_mem    <= {shift_word[len_data-NBIT_DATA_LEN-1:0], rx_data_in};
        addr_mem_inst <= addr;
      end

      if (state == S_WRITE) begin
        word_count <= word_count + 1'b1;
        if (ins_to_mem != HALT_WORD && addr != ADDR_LAST) addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
`timescale 1ns/1ps
// Bench for inst_loader: two instances (11-bit and 2-bit address) checked
// against a byte-stream reference model of the loading protocol.
module tb_inst_loader;

  localparam logic [31:0] HALT = 32'hFC000000;
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  data = '0;

  logic        tick_a, tick_b;
  logic [10:0] addr_a;
  logic [31:0] ins_a;
  logic        wr_a, loading_a, done_a, err_a;
  logic [11:0] wc_a;
  logic [1:0]  addr_b;
  logic [31:0] ins_b;
  logic        wr_b, loading_b, done_b, err_b;
  logic [2:0]  wc_b;

  assign tick_a = tick & ~sel;
  assign tick_b = tick & sel;

  always #5 clk = ~clk;

  inst_loader dut_a (
    .clk(clk), .reset(reset), .rx_done_tick(tick_a), .rx_data_in(data),
    .addr_mem_inst(addr_a), .ins_to_mem(ins_a), .wr_ram_inst(wr_a),
    .loading(loading_a), .load_done(done_a), .load_err(err_a), .word_count(wc_a)
  );

  inst_loader #(.len_addr(2)) dut_b (
    .clk(clk), .reset(reset), .rx_done_tick(tick_b), .rx_data_in(data),
    .addr_mem_inst(addr_b), .ins_to_mem(ins_b), .wr_ram_inst(wr_b),
    .loading(loading_b), .load_done(done_b), .load_err(err_b), .word_count(wc_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: protocol state per instance, fed one byte at a time.
  int          m_mode [2];
  int          m_nb   [2];
  int          m_addr [2];
  int          m_cnt  [2];
  logic [31:0] m_word [2];
  int          m_max  [2] = '{2047, 3};
  logic [42:0] exp_a[$], exp_b[$], act_a[$], act_b[$];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_nb[k] = 0; m_addr[k] = 0; m_cnt[k] = 0; m_word[k] = '0;
    end
  endfunction

  function automatic void model_feed(int k, logic [7:0] b);
    logic [42:0] e;
    if (m_mode[k] == M_IDLE) begin
      if (b == 8'h01) begin
        m_mode[k] = M_LOAD; m_nb[k] = 0; m_addr[k] = 0; m_cnt[k] = 0;
      end
    end else if (m_mode[k] == M_LOAD) begin
      m_word[k] = {m_word[k][23:0], b};
      m_nb[k]++;
      if (m_nb[k] == 4) begin
        m_nb[k] = 0;
        e = {11'(m_addr[k]), m_word[k]};
        if (k == 0) exp_a.push_back(e); else exp_b.push_back(e);
        m_cnt[k]++;
        if (m_word[k] == HALT)            m_mode[k] = M_DONE;
        else if (m_addr[k] == m_max[k])   m_mode[k] = M_ERR;
        else                              m_addr[k]++;
      end
    end
  endfunction

  // Each write pulse spans exactly one negedge; a stretched pulse shows as a duplicate.
  always @(negedge clk) begin
    if (wr_a) act_a.push_back({addr_a, ins_a});
    if (wr_b) act_b.push_back({9'b0, addr_b, ins_b});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tick = 1'b1;
    data = b;
    @(posedge clk);
    model_feed(sel ? 1 : 0, b);
    #1;
    tick = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic check_writes(input int k);
    if (k == 0) begin
      check("a_nwrites", act_a.size(), exp_a.size());
      for (int i = 0; i < act_a.size() && i < exp_a.size(); i++)
        check($sformatf("a_write%0d", i), act_a[i], exp_a[i]);
      act_a.delete(); exp_a.delete();
    end else begin
      check("b_nwrites", act_b.size(), exp_b.size());
      for (int i = 0; i < act_b.size() && i < exp_b.size(); i++)
        check($sformatf("b_write%0d", i), act_b[i], exp_b[i]);
      act_b.delete(); exp_b.delete();
    end
  endtask

  task automatic check_state(input int k);
    if (k == 0) begin
      check("a_loading", loading_a, m_mode[0] == M_LOAD);
      check("a_done",    done_a,    m_mode[0] == M_DONE);
      check("a_err",     err_a,     m_mode[0] == M_ERR);
      check("a_wcount",  wc_a,      m_cnt[0]);
    end else begin
      check("b_loading", loading_b, m_mode[1] == M_LOAD);
      check("b_done",    done_b,    m_mode[1] == M_DONE);
      check("b_err",     err_b,     m_mode[1] == M_ERR);
      check("b_wcount",  wc_b,      m_cnt[1]);
    end
  endtask

  initial begin
    logic [31:0] w;
    int nw;

    // Reset values
    do_reset(2);
    check("rst_a_outs", {addr_a, ins_a, wr_a, loading_a, done_a, err_a, wc_a}, '0);
    check("rst_b_outs", {addr_b, ins_b, wr_b, loading_b, done_b, err_b, wc_b}, '0);

    // Non-command bytes in IDLE are ignored
    sel = 1'b0;
    send(8'h20);
    send(8'h05);
    idle(2);
    check_writes(0);
    check_state(0);

    // Two-word program with latency checks
    send(8'h01);
    check("cmd_loading", loading_a, 1'b1);
    send_word(32'h20080005);
    check("w0_pulse", {wr_a, addr_a, ins_a}, {1'b1, 11'd0, 32'h20080005});
    check("w0_wc_before", wc_a, 12'd0);
    idle(1);
    check("w0_after", {wr_a, wc_a}, {1'b0, 12'd1});
    send_word(HALT);
    check("halt_pulse", {wr_a, addr_a, ins_a, done_a}, {1'b1, 11'd1, HALT, 1'b0});
    idle(1);
    check("halt_after", {wr_a, done_a, wc_a}, {1'b0, 1'b1, 12'd2});
    idle(2);
    check_writes(0);
    check_state(0);

    // Reset mid-word discards the partial word
    do_reset(1);
    send(8'h01);
    send(8'hAA); send(8'hBB); send(8'hCC);
    do_reset(1);
    send(8'h01);
    send_word(32'h00000000);
    idle(2);
    check_writes(0);
    check_state(0);

    // Back-to-back ticks including ticks during WRITE
    do_reset(1);
    send(8'h01);
    send_word(32'h11223344);
    send_word(32'h55667788);
    send_word(HALT);
    idle(2);
    check_writes(0);
    check_state(0);

    // Overflow on a 4-entry RAM: 5 words give 4 writes then ERR
    sel = 1'b1;
    do_reset(1);
    send(8'h01);
    for (int i = 0; i < 5; i++) send_word(32'h0A000000 + i);
    idle(2);
    check_writes(1);
    check_state(1);

    // Halt at the last address goes to DONE
    do_reset(1);
    send(8'h01);
    for (int i = 0; i < 3; i++) send_word(32'h0B000000 + i);
    send_word(HALT);
    idle(2);
    check_writes(1);
    check_state(1);

    // DONE is sticky: a new command and word are ignored
    send(8'h01);
    send_word(32'h12345678);
    idle(2);
    check_writes(1);
    check_state(1);

    // Randomized programs with random gaps on both instances
    for (int it = 0; it < 8; it++) begin
      sel = it[0];
      do_reset(1);
      repeat ($urandom_range(0, 2)) begin
        w[7:0] = 8'($urandom);
        if (w[7:0] == 8'h01) w[7:0] = 8'h02;
        send(w[7:0]);
      end
      send(8'h01);
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) begin
        w = $urandom;
        if (w == HALT) w = w ^ 32'h1;
        if (i == nw - 1 && $urandom_range(0, 3) != 0) w = HALT;
        for (int b = 3; b >= 0; b--) begin
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
          send(w[b*8 +: 8]);
        end
      end
      idle(3);
      check_writes(sel ? 1 : 0);
      check_state(sel ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
